arc4_key_search: RTL and testbench
==================================

// Module: arc4_key_search
// PURPOSE
// - Brute-force key-search sequencer for one arc4 core. Steps a 24-bit candidate key, starts a decrypt per key,
//   and snoops the core's plaintext writes.
// - Declares a key found when every message byte is printable ASCII. Sits between the system control FSM and one
//   arc4 instance; the CT/PT memories stay attached to arc4.
// PARAMETERS
// - KEY_START  24'h000000  first candidate key
// - KEY_STEP   24'h000001  increment between candidates (2 with START 0/1 splits the space across two searchers)
// - KEY_LAST   24'hFFFFFF  last candidate tried before giving up
// PORTS
// - clk        in   1   single clock
// - rst        in   1   synchronous, active-high reset
// - en         in   1   start request; sampled only while rdy=1
// - rdy        out  1   1 = idle, ready for en
// - key_valid  out  1   1 = last search found a key (stable until next en)
// - key        out  24  found key (0 when key_valid=0)
// - arc_en     out  1   one-cycle start pulse to arc4
// - arc_rdy    in   1   arc4 ready (high when arc4 idle)
// - arc_key    out  24  candidate key to arc4; held constant while arc4 busy
// - pt_wren    in   1   snooped arc4 plaintext write enable
// - pt_addr    in   8   snooped plaintext write address
// - pt_wrdata  in   8   snooped plaintext write data
// BEHAVIOUR
// - Reset values: rdy=1, key_valid=0, key=0, arc_en=0, arc_key=KEY_START, state=IDLE, bad=0, len=0.
// - FSM: IDLE -> LAUNCH -> WAIT_BUSY -> RUN -> JUDGE -> (LAUNCH | DONE); DONE -> IDLE.
//   - IDLE: rdy=1. en=1 -> clear key_valid/key, arc_key<=KEY_START, go LAUNCH; rdy=0 from next cycle.
//   - LAUNCH: wait for arc_rdy=1, then assert arc_en for exactly 1 cycle, clear bad and len, go WAIT_BUSY.
//   - WAIT_BUSY: wait for arc_rdy=0 (the core accepted the start), go RUN.
//   - RUN: snoop writes. pt_wren & addr==0 -> len<=pt_wrdata.
//     pt_wren & 1<=addr<=len & (data<8'h20 | data>8'h7E) -> bad<=1. Writes with addr>len are ignored.
//     arc_rdy=1 -> JUDGE.
//   - JUDGE (1 cycle):
//     - bad=0 -> key<=arc_key, key_valid<=1, go DONE.
//     - bad=1 and arc_key==KEY_LAST -> key_valid<=0, go DONE.
//     - else arc_key<=arc_key+KEY_STEP (mod 2^24), go LAUNCH.
//   - DONE: one cycle, then IDLE with rdy=1.
// - Length byte (addr 0) is never range-checked. len=0 means an empty message, and the first key is accepted.
// - KEY_LAST is compared for equality. If stepping would pass KEY_LAST without hitting it, the search ends
//   when the wrapped sum < arc_key.
// - Per-key overhead: 3 cycles beyond arc4 runtime (LAUNCH, WAIT_BUSY, JUDGE).
// - Total latency: en to rdy=1 = sum of arc4 runtimes + 3 per key + 2.
// - en while rdy=0 is ignored. en held high at DONE->IDLE starts a new search (key_valid cleared).
// - rst mid-search: IDLE next cycle with reset values. The top level must reset arc4 from the same rst
//   (arc4 rst_n = ~rst), so no stale arc4 run survives.
// - Simultaneous pt_wren and arc_rdy rise in RUN: the write is still checked before JUDGE.
// STRUCTURE
// - arc4_pkg: typedef logic [23:0] arc4_key_t; localparams PRINT_LO=8'h20, PRINT_HI=8'h7E;
//   typedef enum {IDLE,LAUNCH,WAIT_BUSY,RUN,JUDGE,DONE} ks_state_t.
// - Sub-module pt_printable_mon: owns len, bad, and the RUN-state snoop.
//   - Inputs: clear, active, pt_wren, pt_addr, pt_wrdata.
//   - Output: bad.
//   - Instantiated once; the FSM, key counter and outputs stay in arc4_key_search.
// TESTING
// - Reset: rst=1 for 5 cycles -> rdy=1, key_valid=0, arc_en=0, arc_key=24'h000000.
// - Real arc4 core, CT = test1.memh (encrypted with 24'h00033C), KEY_START=0, en pulse ->
//   arc_en pulses 0x33D times, key_valid=1, key=24'h00033C, and PT memory equals test1_pt.memh.
// - arc4 stub (10-cycle runtime, writes len=3 then bytes), first key bytes {41,0A,42} then {41,42,43} ->
//   first key rejected; key=24'h000001, key_valid=1, 2 launches total.
// - Stub always emits 8'h7F, KEY_START=24'hFFFFFD, KEY_LAST=24'hFFFFFF -> 3 launches, key_valid=0, rdy=1.
// - Stub emitting len=0 -> key=KEY_START accepted after 1 launch.
//   en pulsed during RUN -> no extra launch.
// - rst asserted 2 cycles into RUN -> next cycle rdy=1, arc_en=0.
//   A new en then restarts from KEY_START and completes correctly.

Source files
------------

// File: rtl/arc4_key_search_pkg.sv
// Shared types and constants for the arc4 brute-force key search block.
package arc4_key_search_pkg;

  typedef logic [23:0] arc4_key_t;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    RUN,
    JUDGE,
    DONE
  } ks_state_t;

endpackage

// File: rtl/arc4_key_search_if.sv
// Control, arc4-side and plaintext-snoop signals of the key searcher, bundled.
// Handshakes: en is sampled only while rdy=1; arc_en is a one-cycle start taken when arc_rdy=1,
// and the core acknowledges by dropping arc_rdy, raising it again when its run is finished.
interface arc4_key_search_if;
  logic                            en;
  logic                            rdy;
  logic                            key_valid;
  arc4_key_search_pkg::arc4_key_t  key;
  logic                            arc_en;
  logic                            arc_rdy;
  arc4_key_search_pkg::arc4_key_t  arc_key;
  logic                            pt_wren;
  logic [7:0]                      pt_addr;
  logic [7:0]                      pt_wrdata;
  arc4_key_search_pkg::ks_state_t  state;

  modport master (
    input  en, arc_rdy, pt_wren, pt_addr, pt_wrdata,
    output rdy, key_valid, key, arc_en, arc_key, state
  );

  modport slave (
    output en, arc_rdy, pt_wren, pt_addr, pt_wrdata,
    input  rdy, key_valid, key, arc_en, arc_key, state
  );
endinterface

// File: rtl/arc4_key_search_pt_printable_mon.sv
// Watches arc4 plaintext writes for one run and flags any non-printable message byte.
module pt_printable_mon
  import arc4_key_search_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       active,
  input  logic       pt_wren,
  input  logic [7:0] pt_addr,
  input  logic [7:0] pt_wrdata,
  output logic       bad
);

  logic [7:0] len;

  // Address 0 carries the message length and is never range-checked itself.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      len <= 8'h00;
      bad <= 1'b0;
    end else if (active && pt_wren) begin
      if (pt_addr == 8'h00) begin
        len <= pt_wrdata;
      end else if (pt_addr <= len && (pt_wrdata < PRINT_LO || pt_wrdata > PRINT_HI)) begin
        bad <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/arc4_key_search.sv
// Brute-force key search sequencer: steps candidate keys through one arc4 core and accepts
// the first key whose decrypted message is entirely printable ASCII.
module arc4_key_search
  import arc4_key_search_pkg::*;
#(
  parameter arc4_key_t KEY_START = 24'h000000,
  parameter arc4_key_t KEY_STEP  = 24'h000001,
  parameter arc4_key_t KEY_LAST  = 24'hFFFFFF
) (
  input  logic               clk,
  input  logic               rst,
  arc4_key_search_if.master  bus
);

  ks_state_t state_q, state_d;
  logic      bad;
  logic      launch_fire;
  logic      judge_stop;
  arc4_key_t next_key;

  assign next_key   = bus.arc_key + KEY_STEP;
  // Stop on an exact hit of KEY_LAST, or when the step wraps past the top of the key space.
  assign judge_stop = (bus.arc_key == KEY_LAST) || (next_key < bus.arc_key);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.en)       state_d = LAUNCH;
      LAUNCH:    if (bus.arc_rdy)  state_d = WAIT_BUSY;
      WAIT_BUSY: if (!bus.arc_rdy) state_d = RUN;
      RUN:       if (bus.arc_rdy)  state_d = JUDGE;
      JUDGE:     state_d = (!bad || judge_stop) ? DONE : LAUNCH;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    launch_fire = (state_q == LAUNCH) && bus.arc_rdy;
    bus.rdy     = (state_q == IDLE);
    bus.arc_en  = launch_fire;
    bus.state   = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.key_valid <= 1'b0;
      bus.key       <= '0;
      bus.arc_key   <= KEY_START;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            bus.key_valid <= 1'b0;
            bus.key       <= '0;
            bus.arc_key   <= KEY_START;
          end
        end
        JUDGE: begin
          if (!bad) begin
            bus.key       <= bus.arc_key;
            bus.key_valid <= 1'b1;
          end else if (judge_stop) begin
            bus.key_valid <= 1'b0;
          end else begin
            bus.arc_key   <= next_key;
          end
        end
        default: ;
      endcase
    end
  end

  pt_printable_mon u_mon (
    .clk       (clk),
    .rst       (rst),
    .clear     (launch_fire),
    .active    (state_q == RUN),
    .pt_wren   (bus.pt_wren),
    .pt_addr   (bus.pt_addr),
    .pt_wrdata (bus.pt_wrdata),
    .bad       (bad)
  );

endmodule

// File: tb/tb_arc4_key_search.sv
// Directed bench for arc4_key_search driving a behavioural arc4 stub (10-cycle runs).
module tb_arc4_key_search;
  import arc4_key_search_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;

  // Stub state: shared by both DUTs; only the DUT chosen by sel gets launches.
  logic       stub_rdy;
  logic       stub_wren;
  logic [7:0] stub_addr;
  logic [7:0] stub_data;
  int         mode;
  int         launches;
  int         sel;
  logic       sel_arc_en;

  arc4_key_search_if ifc0 ();
  arc4_key_search_if ifc1 ();

  assign ifc0.arc_rdy   = stub_rdy;
  assign ifc0.pt_wren   = stub_wren;
  assign ifc0.pt_addr   = stub_addr;
  assign ifc0.pt_wrdata = stub_data;
  assign ifc1.arc_rdy   = stub_rdy;
  assign ifc1.pt_wren   = stub_wren;
  assign ifc1.pt_addr   = stub_addr;
  assign ifc1.pt_wrdata = stub_data;
  assign sel_arc_en     = (sel == 1) ? ifc1.arc_en : ifc0.arc_en;

  arc4_key_search dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifc0.master)
  );

  arc4_key_search #(
    .KEY_START (24'hFFFFFD),
    .KEY_STEP  (24'h000001),
    .KEY_LAST  (24'hFFFFFF)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- arc4 stub ----------------
  function automatic logic [7:0] stub_len();
    return (mode == 2) ? 8'd0 : 8'd3;
  endfunction

  function automatic logic [7:0] stub_byte(input int idx);
    logic [7:0] b;
    b = 8'h7F;
    case (mode)
      0: if (launches == 1) b = (idx == 1) ? 8'h41 : (idx == 2) ? 8'h0A : 8'h42;
         else               b = (idx == 1) ? 8'h41 : (idx == 2) ? 8'h42 : 8'h43;
      3: if (launches == 1) b = (idx == 1) ? 8'h41 : (idx == 2) ? 8'h42 : 8'h7F;
         else               b = (idx == 1) ? 8'h41 : (idx == 2) ? 8'h42 : 8'h43;
      default: b = 8'h7F;
    endcase
    return b;
  endfunction

  initial begin
    int  cnt;
    bit  pend;
    int  last_at;
    stub_rdy  = 1'b1;
    stub_wren = 1'b0;
    stub_addr = 8'h00;
    stub_data = 8'h00;
    cnt  = 0;
    pend = 0;
    forever begin
      @(negedge clk);
      stub_wren = 1'b0;
      last_at = (mode == 3) ? 0 : 5;
      if (rst) begin
        stub_rdy = 1'b1;
        cnt  = 0;
        pend = 0;
      end else if (pend) begin
        pend     = 0;
        stub_rdy = 1'b0;
        cnt      = 10;
      end else if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 8) begin
          stub_wren = 1'b1; stub_addr = 8'd0; stub_data = stub_len();
        end else if (cnt == 7) begin
          stub_wren = 1'b1; stub_addr = 8'd1; stub_data = stub_byte(1);
        end else if (cnt == 6) begin
          stub_wren = 1'b1; stub_addr = 8'd2; stub_data = stub_byte(2);
        end else if (cnt == last_at) begin
          stub_wren = 1'b1; stub_addr = 8'd3; stub_data = stub_byte(3);
        end
        if (cnt == 0) stub_rdy = 1'b1;
      end else if (sel_arc_en) begin
        pend     = 1;
        launches = launches + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_en(input int which);
    @(negedge clk);
    if (which == 1) ifc1.en = 1'b1; else ifc0.en = 1'b1;
    @(negedge clk);
    if (which == 1) ifc1.en = 1'b0; else ifc0.en = 1'b0;
  endtask

  task automatic wait_rdy(input int which, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if ((which == 1 ? ifc1.rdy : ifc0.rdy) === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input ks_state_t s, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifc0.state == s) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ifc0.rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b want 1", ifc0.rdy); end
    tests_run++;
    if (ifc0.key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid: got %b want 0", ifc0.key_valid); end
    tests_run++;
    if (ifc0.arc_en !== 1'b0) begin fails++; $display("FAIL reset_arc_en: got %b want 0", ifc0.arc_en); end
    tests_run++;
    if (ifc0.arc_key !== 24'h000000) begin fails++; $display("FAIL reset_arc_key: got %h want 000000", ifc0.arc_key); end
    tests_run++;
    if (ifc0.key !== 24'h000000) begin fails++; $display("FAIL reset_key: got %h want 000000", ifc0.key); end
    tests_run++;
    if (ifc1.arc_key !== 24'hFFFFFD) begin fails++; $display("FAIL reset_arc_key_dut1: got %h want fffffd", ifc1.arc_key); end
  endtask

  task automatic test_first_reject();
    bit ok;
    sel = 0; mode = 0; launches = 0;
    pulse_en(0);
    tests_run++;
    if (ifc0.rdy !== 1'b0) begin fails++; $display("FAIL reject_busy_rdy: got %b want 0", ifc0.rdy); end
    wait_rdy(0, 200, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL reject_timeout: rdy got 0 want 1"); end
    tests_run++;
    if (ifc0.key_valid !== 1'b1) begin fails++; $display("FAIL reject_key_valid: got %b want 1", ifc0.key_valid); end
    tests_run++;
    if (ifc0.key !== 24'h000001) begin fails++; $display("FAIL reject_key: got %h want 000001", ifc0.key); end
    tests_run++;
    if (launches != 2) begin fails++; $display("FAIL reject_launches: got %0d want 2", launches); end
  endtask

  task automatic test_exhaust();
    bit ok;
    sel = 1; mode = 1; launches = 0;
    pulse_en(1);
    wait_rdy(1, 200, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL exhaust_timeout: rdy got 0 want 1"); end
    tests_run++;
    if (launches != 3) begin fails++; $display("FAIL exhaust_launches: got %0d want 3", launches); end
    tests_run++;
    if (ifc1.key_valid !== 1'b0) begin fails++; $display("FAIL exhaust_key_valid: got %b want 0", ifc1.key_valid); end
    tests_run++;
    if (ifc1.key !== 24'h000000) begin fails++; $display("FAIL exhaust_key: got %h want 000000", ifc1.key); end
    tests_run++;
    if (ifc1.arc_key !== 24'hFFFFFF) begin fails++; $display("FAIL exhaust_arc_key: got %h want ffffff", ifc1.arc_key); end
  endtask

  task automatic test_empty_msg();
    bit ok;
    sel = 0; mode = 2; launches = 0;
    pulse_en(0);
    wait_state(RUN, 50, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL empty_run_timeout: state got %0d want RUN", ifc0.state); end
    pulse_en(0);
    wait_rdy(0, 200, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL empty_timeout: rdy got 0 want 1"); end
    repeat (20) @(negedge clk);
    tests_run++;
    if (launches != 1) begin fails++; $display("FAIL empty_launches: got %0d want 1", launches); end
    tests_run++;
    if (ifc0.key_valid !== 1'b1 || ifc0.key !== 24'h000000) begin
      fails++; $display("FAIL empty_key: got valid=%b key=%h want valid=1 key=000000", ifc0.key_valid, ifc0.key);
    end
  endtask

  task automatic test_simul_write();
    bit ok;
    sel = 0; mode = 3; launches = 0;
    pulse_en(0);
    wait_rdy(0, 200, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL simul_timeout: rdy got 0 want 1"); end
    tests_run++;
    if (ifc0.key !== 24'h000001 || ifc0.key_valid !== 1'b1) begin
      fails++; $display("FAIL simul_key: got valid=%b key=%h want valid=1 key=000001", ifc0.key_valid, ifc0.key);
    end
    tests_run++;
    if (launches != 2) begin fails++; $display("FAIL simul_launches: got %0d want 2", launches); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    sel = 0; mode = 0; launches = 0;
    pulse_en(0);
    wait_state(RUN, 50, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL midrst_run_timeout: state got %0d want RUN", ifc0.state); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (ifc0.rdy !== 1'b1 || ifc0.arc_en !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs: got rdy=%b arc_en=%b want rdy=1 arc_en=0", ifc0.rdy, ifc0.arc_en);
    end
    tests_run++;
    if (ifc0.arc_key !== 24'h000000 || ifc0.key_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_regs: got arc_key=%h valid=%b want 000000 0", ifc0.arc_key, ifc0.key_valid);
    end
    repeat (2) @(negedge clk);
    launches = 0;
    pulse_en(0);
    wait_rdy(0, 200, ok);
    tests_run++;
    if (!ok || ifc0.key !== 24'h000001 || ifc0.key_valid !== 1'b1 || launches != 2) begin
      fails++; $display("FAIL midrst_restart: got ok=%0d key=%h valid=%b launches=%0d want 1 000001 1 2",
                        ok, ifc0.key, ifc0.key_valid, launches);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    sel = 0; mode = 2; launches = 0;
    @(negedge clk);
    ifc0.en = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (launches >= 2) begin ok = 1; break; end
    end
    ifc0.en = 1'b0;
    tests_run++;
    if (!ok) begin fails++; $display("FAIL b2b_restart: launches got %0d want 2", launches); end
    tests_run++;
    if (ifc0.key_valid !== 1'b0) begin fails++; $display("FAIL b2b_cleared: key_valid got %b want 0", ifc0.key_valid); end
    wait_rdy(0, 200, ok);
    repeat (20) @(negedge clk);
    tests_run++;
    if (!ok || ifc0.key_valid !== 1'b1 || launches != 2) begin
      fails++; $display("FAIL b2b_final: got ok=%0d valid=%b launches=%0d want 1 1 2", ok, ifc0.key_valid, launches);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run = 0;
    fails     = 0;
    rst       = 1'b1;
    ifc0.en   = 1'b0;
    ifc1.en   = 1'b0;
    mode      = 0;
    sel       = 0;
    launches  = 0;
    test_reset();
    test_first_reject();
    test_exhaust();
    test_empty_msg();
    test_simul_write();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
